// File: rtl/logic_chain_pkg.sv
// Shared types and the bitwise operator helper for the logic chain pipeline.
package logic_chain_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_t;

  // Operands are widened to this word so a single function serves every WIDTH <= 64.
  localparam int unsigned OP_MAX_W = 64;
  typedef logic [OP_MAX_W-1:0] op_word_t;

  function automatic op_word_t apply_op(input op_t op, input op_word_t x, input op_word_t y);
    op_word_t r;
    r = '0;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_chain_pipe_stage.sv
// Generic valid/ready register slice; payload holds while the downstream stalls.
// Handshake: a beat moves when valid && ready; valid never drops and data never
// changes while valid is high and ready is low.
module pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/logic_chain_pipe.sv
// Two-stage pipelined gate chain: d = a op b, e = (fresh or previous d) op c,
// with valid/ready on both sides and a completed-transaction counter.
module logic_chain_pipe
  import logic_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       op,
  input  logic             chain_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned S1_W = 2 * WIDTH + 3;
  localparam int unsigned S2_W = 2 * WIDTH;

  logic [WIDTH-1:0] d_new;
  logic [S1_W-1:0]  s1_in;
  logic [S1_W-1:0]  s1_q;
  logic             s1_v;
  logic             s2_ready;
  logic             s1_advance;
  logic [WIDTH-1:0] s1_d;
  logic [WIDTH-1:0] s1_c;
  op_t              s1_op;
  logic             s1_mode;
  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] chain_src;
  logic [WIDTH-1:0] e_next;
  logic [S2_W-1:0]  s2_in;
  logic [S2_W-1:0]  s2_q;

  // op and chain_mode travel with the transaction so later input changes cannot affect it.
  assign d_new = WIDTH'(apply_op(op_t'(op), op_word_t'(a), op_word_t'(b)));
  assign s1_in = {d_new, c, op, chain_mode};

  pipe_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_v),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  assign s1_d       = s1_q[S1_W-1 -: WIDTH];
  assign s1_c       = s1_q[WIDTH+2 -: WIDTH];
  assign s1_op      = op_t'(s1_q[2:1]);
  assign s1_mode    = s1_q[0];
  assign s1_advance = s1_v && s2_ready;

  // prev_d is read before its own update on the same edge (registered chaining).
  assign chain_src = s1_mode ? prev_d : s1_d;
  assign e_next    = WIDTH'(apply_op(s1_op, op_word_t'(chain_src), op_word_t'(s1_c)));
  assign s2_in     = {s1_d, e_next};

  pipe_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_v),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign d = s2_q[S2_W-1 -: WIDTH];
  assign e = s2_q[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_d <= '0;
    end else if (s1_advance) begin
      prev_d <= s1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_chain_pipe.sv
// Self-checking bench for logic_chain_pipe: vector table, stall/reset sequences, scoreboard queue.
module tb_logic_chain_pipe;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0, c = '0;
  logic [1:0]    op = 2'b00;
  logic          chain_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  d, e;
  logic [CW-1:0] txn_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model_prev = '0;
  logic [CW-1:0]  exp_cnt = '0;

  typedef struct {
    logic         pre_rst;
    logic [W-1:0] va, vb, vc;
    logic [1:0]   vop;
    logic         vmode;
    logic [W-1:0] ed, ee;
  } vec_t;

  vec_t vecs[9];

  logic_chain_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .c          (c),
    .op         (op),
    .chain_mode (chain_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d          (d),
    .e          (e),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] f_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x ^ y);
    endcase
  endfunction

  // Scoreboard: every completed handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got d=%0h e=%0h expected no output", d, e);
      end else begin
        check("out_de", {16'h0, d, e}, {16'h0, exp_q.pop_front()});
      end
      exp_cnt = exp_cnt + 1'b1;
    end
  end

  // Drivers assume they start at posedge+1 and return at posedge+1.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tc,
                      input logic [1:0] top, input logic tm, input logic [W-1:0] ed, input logic [W-1:0] ee);
    bit acc;
    acc = 0;
    a = ta; b = tb; c = tc; op = top; chain_mode = tm; in_valid = 1'b1;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        exp_q.push_back({ed, ee});
        model_prev = ed;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected accept within 60 cycles");
    end
  endtask

  task automatic send_m(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tc,
                        input logic [1:0] top, input logic tm);
    logic [W-1:0] ed, ee;
    ed = f_op(top, ta, tb);
    ee = f_op(top, tm ? model_prev : ed, tc);
    send(ta, tb, tc, top, tm, ed, ee);
  endtask

  task automatic rst_pulse(input int n);
    rst = 1'b1;
    exp_q.delete();
    model_prev = '0;
    exp_cnt = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done;
    logic [W-1:0] hd, he;

    vecs[0] = '{1'b1, 8'hF0, 8'h3C, 8'hFF, 2'b00, 1'b0, 8'h30, 8'h30};
    vecs[1] = '{1'b1, 8'hFF, 8'h0F, 8'hF0, 2'b00, 1'b1, 8'h0F, 8'h00};
    vecs[2] = '{1'b0, 8'hFF, 8'hF0, 8'hFF, 2'b00, 1'b1, 8'hF0, 8'h0F};
    vecs[3] = '{1'b0, 8'hAA, 8'h55, 8'h0F, 2'b10, 1'b0, 8'hFF, 8'hF0};
    vecs[4] = '{1'b0, 8'hAA, 8'h55, 8'h0F, 2'b11, 1'b0, 8'h00, 8'hF0};
    vecs[5] = '{1'b0, 8'h12, 8'h34, 8'hC0, 2'b01, 1'b0, 8'h36, 8'hF6};
    vecs[6] = '{1'b0, 8'h01, 8'h02, 8'h80, 2'b01, 1'b1, 8'h03, 8'hB6};
    vecs[7] = '{1'b0, 8'h0F, 8'h0F, 8'h55, 2'b10, 1'b1, 8'h00, 8'h56};
    vecs[8] = '{1'b0, 8'h00, 8'hFF, 8'h00, 2'b11, 1'b1, 8'h00, 8'hFF};

    @(posedge clk); #1;
    rst_pulse(2);
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_txn_count", {28'h0, txn_count}, 32'h0);
    check("rst_de", {16'h0, d, e}, 32'h0);
    @(posedge clk); #1;

    // Single transaction with latency check.
    send(8'hF0, 8'h3C, 8'hFF, 2'b00, 1'b0, 8'h30, 8'h30);
    @(negedge clk);
    check("lat_cycle1_out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_cycle2_out_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    drain();
    check("single_txn_count", {28'h0, txn_count}, 32'h1);

    // Table vectors, back-to-back unless a reset is requested first.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].pre_rst) begin
        drain();
        rst_pulse(1);
      end
      send(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vop, vecs[i].vmode, vecs[i].ed, vecs[i].ee);
    end
    drain();

    // Backpressure: two transactions fill the pipe, the third waits.
    rst_pulse(1);
    out_ready = 1'b0;
    fork
      begin
        send_m(8'hF0, 8'h3C, 8'h0F, 2'b00, 1'b0);
        send_m(8'h0F, 8'h0F, 8'hFF, 2'b01, 1'b0);
        send_m(8'h55, 8'hAA, 8'h00, 2'b10, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", {31'h0, in_ready}, 32'h0);
        check("stall_out_valid", {31'h0, out_valid}, 32'h1);
        check("stall_head", {16'h0, d, e}, {16'h0, 8'h30, 8'h00});
        hd = d;
        he = e;
        repeat (3) begin
          @(negedge clk);
          check("stall_hold", {15'h0, in_ready, d, e}, {15'h0, 1'b0, hd, he});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_txn_count", {28'h0, txn_count}, 32'h3);

    // Random operands with random consumer stalls.
    rst_pulse(1);
    done = 0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send_m(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("random_txn_count", {28'h0, txn_count}, {28'h0, exp_cnt});

    // Counter wrap: 17 completes on a 4-bit counter.
    rst_pulse(1);
    for (int i = 0; i < 17; i++)
      send_m(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    drain();
    check("wrap_txn_count", {28'h0, txn_count}, 32'h1);

    // Reset with both stages occupied; an input presented during reset must be ignored.
    out_ready = 1'b0;
    send_m(8'h11, 8'h22, 8'h33, 2'b01, 1'b0);
    send_m(8'h44, 8'h55, 8'h66, 2'b10, 1'b0);
    a = 8'h77; b = 8'h88; c = 8'h99; op = 2'b01; chain_mode = 1'b0; in_valid = 1'b1;
    rst_pulse(1);
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    check("midrst_txn_count", {28'h0, txn_count}, 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst_no_emerge", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    send(8'h3C, 8'hFF, 8'hFF, 2'b00, 1'b1, 8'h3C, 8'h00);
    drain();
    check("midrst_after_count", {28'h0, txn_count}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
